// File: rtl/tlu_dut_rx_pkg.sv
// tlu_dut_rx_pkg
// Shared definitions for the TLU DUT-side receiver: receiver state encoding,
// width of the received trigger ID and width of the trigger/timestamp counters.
package tlu_dut_rx_pkg;

  localparam int TRIG_ID_W = 31;
  localparam int CNT_W     = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACK,
    ST_CLK_LOW,
    ST_CLK_HIGH,
    ST_OUT
  } state_e;

endpackage

// File: rtl/tlu_in_sync.sv
// tlu_in_sync
// Two-flop synchroniser for the asynchronous TLU trigger/data line, followed by
// a one-sample history flop used as a glitch filter.
//   clk_i   in  system clock
//   rst_i   in  asynchronous active-high reset
//   line_i  in  raw asynchronous line
//   line_o  out synchronised line (second sync flop)
//   high_o  out two consecutive synchronised samples high
//   low_o   out two consecutive synchronised samples low
module tlu_in_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic line_i,
  output logic line_o,
  output logic high_o,
  output logic low_o
);

  logic meta_q;
  logic sync_q;
  logic hist_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      hist_q <= 1'b0;
    end else begin
      meta_q <= line_i;
      sync_q <= meta_q;
      hist_q <= sync_q;
    end
  end

  assign line_o = sync_q;
  assign high_o = sync_q & hist_q;
  assign low_o  = ~sync_q & ~hist_q;

endmodule

// File: rtl/tlu_dut_rx.sv
// tlu_dut_rx
// DUT-side receiver for the TLU trigger handshake: detects a trigger, raises
// BUSY, clocks the serial trigger ID in LSB first and hands it to a consumer
// under a VALID/READY handshake while holding BUSY as back-pressure.
//   SYS_CLK            in  system clock
//   SYS_RST            in  asynchronous active-high reset
//   ENABLE             in  accept new triggers
//   N_BITS_TRIGGER_ID  in  number of ID bits to clock out (0..31)
//   TLU_TRIGGER        in  asynchronous trigger / serial ID line
//   TLU_BUSY           out handshake busy
//   TLU_CLOCK          out ID shift clock
//   TRIG_ID            out received ID (bits above N read 0)
//   TRIG_ID_VALID      out ID available
//   TRIG_ID_READY      in  consumer accepts
//   TRIG_CNT           out accepted-trigger count
//   TIMESTAMP          out SYS_CLK count latched at acceptance
//                          (only with macro TLU_DUT_RX_TIMESTAMP_EN)
//
// state       | meaning
// ST_IDLE     | BUSY low, waiting for a filtered trigger while ENABLE is high
// ST_ACK      | BUSY high, waiting for the TLU to release the trigger line
// ST_CLK_LOW  | TLU_CLOCK low phase, CLK_DIV cycles
// ST_CLK_HIGH | TLU_CLOCK high phase, CLK_DIV cycles, bit sampled on last cycle
// ST_OUT      | ID presented with VALID, BUSY held until READY
module tlu_dut_rx
  import tlu_dut_rx_pkg::*;
#(
  parameter int CLK_DIV = 8,
  parameter int INV_IN  = 0
) (
  input  logic                 SYS_CLK,
  input  logic                 SYS_RST,
  input  logic                 ENABLE,
  input  logic [4:0]           N_BITS_TRIGGER_ID,
  input  logic                 TLU_TRIGGER,
  output logic                 TLU_BUSY,
  output logic                 TLU_CLOCK,
  output logic [TRIG_ID_W-1:0] TRIG_ID,
  output logic                 TRIG_ID_VALID,
  input  logic                 TRIG_ID_READY,
`ifdef TLU_DUT_RX_TIMESTAMP_EN
  output logic [CNT_W-1:0]     TIMESTAMP,
`endif
  output logic [CNT_W-1:0]     TRIG_CNT
);

  localparam logic       POL      = (INV_IN != 0);
  localparam logic [7:0] TMR_LOAD = 8'(CLK_DIV - 1);

  state_e               state_q, state_d;
  logic [7:0]           tmr_q, tmr_d;
  logic [4:0]           bit_q, bit_d;
  logic [4:0]           nbits_q, nbits_d;
  logic [TRIG_ID_W-1:0] id_q, id_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 tclk_q, tclk_d;

  logic trig_line;
  logic trig_high;
  logic trig_low;
  logic accept;

  tlu_in_sync u_sync (
    .clk_i  (SYS_CLK),
    .rst_i  (SYS_RST),
    .line_i (TLU_TRIGGER ^ POL),
    .line_o (trig_line),
    .high_o (trig_high),
    .low_o  (trig_low)
  );

  assign accept = (state_q == ST_IDLE) && ENABLE && trig_high;

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    bit_d   = bit_q;
    nbits_d = nbits_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_ACK;
          nbits_d = N_BITS_TRIGGER_ID;
          id_d    = '0;
          cnt_d   = cnt_q + 32'd1;
        end
      end
      ST_ACK: begin
        if (trig_low) begin
          if (nbits_q != 5'd0) begin
            state_d = ST_CLK_LOW;
            tmr_d   = TMR_LOAD;
            bit_d   = 5'd0;
          end else begin
            state_d = ST_OUT;
          end
        end
      end
      ST_CLK_LOW: begin
        if (tmr_q == 8'd0) begin
          state_d = ST_CLK_HIGH;
          tmr_d   = TMR_LOAD;
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      ST_CLK_HIGH: begin
        if (tmr_q == 8'd0) begin
          id_d[bit_q] = trig_line;
          if (bit_q == nbits_q - 5'd1) begin
            state_d = ST_OUT;
          end else begin
            state_d = ST_CLK_LOW;
            tmr_d   = TMR_LOAD;
            bit_d   = bit_q + 5'd1;
          end
        end else begin
          tmr_d = tmr_q - 8'd1;
        end
      end
      ST_OUT: begin
        if (TRIG_ID_READY) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // BUSY/CLOCK are registered from the next state so the TLU sees clean edges.
    busy_d = (state_d != ST_IDLE);
    tclk_d = (state_d == ST_CLK_HIGH);
  end

  always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      nbits_q <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      tclk_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      nbits_q <= nbits_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      tclk_q  <= tclk_d;
    end
  end

`ifdef TLU_DUT_RX_TIMESTAMP_EN
  logic [CNT_W-1:0] ts_free_q;
  logic [CNT_W-1:0] ts_lat_q;

  always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      ts_free_q <= '0;
      ts_lat_q  <= '0;
    end else begin
      ts_free_q <= ts_free_q + 32'd1;
      if (accept) begin
        ts_lat_q <= ts_free_q;
      end
    end
  end

  assign TIMESTAMP = ts_lat_q;
`endif

  assign TLU_BUSY      = busy_q ^ POL;
  assign TLU_CLOCK     = tclk_q ^ POL;
  assign TRIG_ID       = id_q;
  assign TRIG_ID_VALID = (state_q == ST_OUT);
  assign TRIG_CNT      = cnt_q;

endmodule

// File: doc/tlu_dut_rx.md
TLU_DUT_RX -- requirements
Module: tlu_dut_rx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 8, the TLU_CLOCK half-period in SYS_CLK cycles (legal 4..255).
REQ-002 SHALL have parameter INV_IN, default 0: when 1, invert TLU_TRIGGER on input and TLU_BUSY/TLU_CLOCK on output.
REQ-003 SHALL have one clock and asynchronous active-high reset: SYS_CLK in 1 system clock; SYS_RST in 1 asynchronous active-high reset.
REQ-004 SHALL have ports:
- ENABLE in 1: accept new triggers.
- N_BITS_TRIGGER_ID in 5: ID bits to clock out, 0..31.
- TLU_TRIGGER in 1: asynchronous trigger/ID serial line.
- TLU_BUSY out 1: handshake busy.
- TLU_CLOCK out 1: ID shift clock.
- TRIG_ID out 31: received ID.
- TRIG_ID_VALID out 1: ID available.
- TRIG_ID_READY in 1: consumer accepts.
- TRIG_CNT out 32: accepted-trigger count.

Function
REQ-005 SHALL synchronise TLU_TRIGGER through 2 flops; "trigger high" means 2 consecutive synchronised samples high (glitch filter).
REQ-006 SHALL implement states IDLE, ACK, CLK_LOW, CLK_HIGH, OUT.
REQ-007 IDLE: TLU_BUSY=0, TLU_CLOCK=0; when ENABLE=1 and trigger high, go to ACK. Pin-to-BUSY latency SHALL be at most 4 SYS_CLK cycles.
REQ-008 ACK: TLU_BUSY=1. Wait for trigger low. Then go to CLK_LOW if N_BITS_TRIGGER_ID>0, else to OUT with TRIG_ID=0.
REQ-009 N_BITS_TRIGGER_ID SHALL be sampled on the IDLE->ACK transition and held for the transaction.
REQ-010 CLK_LOW and CLK_HIGH SHALL each last exactly CLK_DIV cycles, with TLU_CLOCK=0 and 1 respectively.
REQ-011 On the last cycle of CLK_HIGH, the synchronised line value SHALL be stored into TRIG_ID[k] (LSB first), k = bit index 0..N-1.
REQ-012 After bit N-1, go to OUT; otherwise return to CLK_LOW.
REQ-013 Bits k>=N SHALL read 0; the ID register SHALL be cleared on IDLE->ACK.
REQ-014 OUT: TRIG_ID_VALID=1 and TLU_BUSY stays 1 (back-pressure to the TLU). On the VALID&READY cycle, go to IDLE; TLU_BUSY drops on the next cycle.
REQ-015 TRIG_ID SHALL be stable while VALID=1; VALID SHALL never depend combinationally on READY.
REQ-016 TRIG_CNT SHALL increment by 1 on each IDLE->ACK transition and wrap 0xFFFFFFFF->0.
REQ-017 ENABLE deasserted mid-transaction SHALL NOT abort the transaction; it blocks only the next IDLE->ACK.
REQ-018 A trigger held high in IDLE with ENABLE=0 SHALL be ignored; it is accepted if ENABLE rises while the line is still high.
REQ-019 After returning to IDLE, a new trigger SHALL be accepted no earlier than the cycle after TLU_BUSY falls.

Reset
REQ-020 SYS_RST SHALL asynchronously force state IDLE and clear all outputs: TLU_BUSY=0, TLU_CLOCK=0, TRIG_ID=0, TRIG_ID_VALID=0, TRIG_CNT=0, sync flops=0.
REQ-021 Reset mid-transaction SHALL drop TLU_BUSY/TLU_CLOCK immediately and discard the partial ID.

Configuration
REQ-022 With macro TLU_DUT_RX_TIMESTAMP_EN defined, the block SHALL add output TIMESTAMP (32 bits), a free-running SYS_CLK counter (reset 0, wraps).
- The counter value SHALL be latched on IDLE->ACK and presented with TRIG_ID under the same VALID/READY handshake.
- Without the macro, the TIMESTAMP port and its counter SHALL NOT exist.

Structure
REQ-023 A shared package SHALL hold the state enum, TRIG_ID width (31) and counter width (32).
REQ-024 The 2-flop synchroniser plus glitch filter SHALL be a sub-module named tlu_in_sync.

Verification
REQ-025 CLK_DIV=8, N=15, TLU model sends ID 0x1234 -> TLU_BUSY within 4 cycles, 15 TLU_CLOCK pulses each 8 high/8 low, TRIG_ID=0x1234, VALID=1, TRIG_CNT=1.
REQ-026 N=0, one trigger -> no TLU_CLOCK pulse, VALID with TRIG_ID=0, BUSY falls the cycle after READY.
REQ-027 READY held low 100 cycles after VALID -> BUSY and TRIG_ID=0x1234 held 100 cycles; second trigger pulse is not accepted; TRIG_CNT stays 1.
REQ-028 1-cycle glitch on TLU_TRIGGER in IDLE -> no BUSY; TRIG_CNT unchanged.
REQ-029 SYS_RST asserted after 5 of 15 bits -> BUSY/CLOCK 0 immediately; next trigger yields the correct ID 0x7FFF.
REQ-030 With TLU_DUT_RX_TIMESTAMP_EN, triggers at counter 100 and 400 -> TIMESTAMP 100 and 400, each with its own ID.
